// File: rtl/gcd_pkg.sv
// Shared encodings for the subtractive GCD control path: FSM states,
// ALU operation codes and operand mux selects.
package gcd_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_CMP_EQ,
        S_CMP_GT,
        S_SUB_A,
        S_SUB_B,
        S_OUTPUT,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [1:0] ALU_A_MINUS_B = 2'b00;
    localparam logic [1:0] ALU_B_MINUS_A = 2'b01;
    localparam logic [1:0] ALU_CMP_EQ    = 2'b10;
    localparam logic [1:0] ALU_CMP_GT    = 2'b11;

    localparam logic SEL_EXT = 1'b0;
    localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/gcd_iter_counter.sv
// Saturating iteration counter: clear wins over increment, and the count
// sticks at MAX so it can never wrap back below the watchdog limit.
module gcd_iter_counter #(
    parameter int MAX = 15,
    parameter int W   = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         at_limit_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_q, count_d;

    assign at_limit_o = (count_q == MAX_V);
    assign count_o    = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (inc_i && !at_limit_o)
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/gcd_controller.sv
// Moore control FSM for the 4-bit subtractive GCD datapath, with a
// busy/done/error handshake and an iteration watchdog.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int MAX_ITER = 15,
    parameter int ITER_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              x_eq_y,
    input  logic              x_greater_y,
    output logic              enable,
    output logic [1:0]        sel,
    output logic              a_load,
    output logic              b_load,
    output logic              a_sel,
    output logic              b_sel,
    output logic              d_load,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ITER_W-1:0] iter_count
);

    state_e state_q, state_d;
    logic   at_limit;
    logic   cnt_clr, cnt_inc;

    assign cnt_clr = (state_q == S_IDLE) && start;
    assign cnt_inc = (state_q == S_SUB_A) || (state_q == S_SUB_B);

    gcd_iter_counter #(
        .MAX (MAX_ITER),
        .W   (ITER_W)
    ) u_iter (
        .clk_i      (clock),
        .rst_i      (reset),
        .clr_i      (cnt_clr),
        .inc_i      (cnt_inc),
        .count_o    (iter_count),
        .at_limit_o (at_limit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        enable  = 1'b0;
        sel     = ALU_A_MINUS_B;
        a_load  = 1'b0;
        b_load  = 1'b0;
        a_sel   = SEL_EXT;
        b_sel   = SEL_EXT;
        d_load  = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        error   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                a_load  = 1'b1;
                b_load  = 1'b1;
                state_d = S_CMP_EQ;
            end
            S_CMP_EQ: begin
                enable = 1'b1;
                sel    = ALU_CMP_EQ;
                // Equality takes priority so a result on the last allowed step still completes.
                if (x_eq_y)        state_d = S_OUTPUT;
                else if (at_limit) state_d = S_ERROR;
                else               state_d = S_CMP_GT;
            end
            S_CMP_GT: begin
                enable  = 1'b1;
                sel     = ALU_CMP_GT;
                state_d = x_greater_y ? S_SUB_A : S_SUB_B;
            end
            S_SUB_A: begin
                enable  = 1'b1;
                sel     = ALU_A_MINUS_B;
                a_sel   = SEL_SUB;
                a_load  = 1'b1;
                state_d = S_CMP_EQ;
            end
            S_SUB_B: begin
                enable  = 1'b1;
                sel     = ALU_B_MINUS_A;
                b_sel   = SEL_SUB;
                b_load  = 1'b1;
                state_d = S_CMP_EQ;
            end
            S_OUTPUT: begin
                d_load  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                error   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Directed bench for gcd_controller paired with a small behavioural model
// of the 4-bit subtractive datapath (A/B registers, ALU, result register).
module tb_gcd_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       x_eq_y, x_greater_y;
    logic       enable;
    logic [1:0] sel;
    logic       a_load, b_load, a_sel, b_sel, d_load;
    logic       busy, done, error;
    logic [3:0] iter_count;

    logic [3:0] ext_a = 4'd0, ext_b = 4'd0;
    logic [3:0] a_q = 4'd0, b_q = 4'd0, d_q = 4'd0;
    logic [3:0] alu;

    int n_vec = 0;
    int n_bad = 0;

    gcd_controller #(.MAX_ITER(15), .ITER_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .x_eq_y      (x_eq_y),
        .x_greater_y (x_greater_y),
        .enable      (enable),
        .sel         (sel),
        .a_load      (a_load),
        .b_load      (b_load),
        .a_sel       (a_sel),
        .b_sel       (b_sel),
        .d_load      (d_load),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .iter_count  (iter_count)
    );

    always #5 clock = ~clock;

    // Datapath model: flags only meaningful while the ALU runs the matching compare.
    assign alu         = (sel == 2'b01) ? (b_q - a_q) : (a_q - b_q);
    assign x_eq_y      = enable && (sel == 2'b10) && (a_q == b_q);
    assign x_greater_y = enable && (sel == 2'b11) && (a_q > b_q);

    always @(posedge clock) begin
        if (a_load) a_q <= a_sel ? alu : ext_a;
        if (b_load) b_q <= b_sel ? alu : ext_b;
        if (d_load) d_q <= a_q;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        int a;
        int b;
        int done_cyc;   // 0 = no done expected
        int err_cyc;    // 0 = no error expected
        int d;
        int iter;
        int subs;       // single-register load strobes after LOAD
        int glitch;     // pulse start while busy
    } vec_t;

    // Runs one operation starting from IDLE; cycle 1 is the LOAD cycle.
    task automatic run_op(input vec_t v);
        int cyc, done_c, err_c, dl, loads, both, first_ok, dsamp, itr, busy_gap;
        ext_a = v.a[3:0];
        ext_b = v.b[3:0];
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1; done_c = 0; err_c = 0; dl = 0; loads = 0; both = 0;
        dsamp = -1; itr = -1; busy_gap = 0;
        first_ok = (a_load && b_load && !a_sel && !b_sel) ? 1 : 0;
        while (cyc < 100) begin
            if (!busy) busy_gap++;
            if (d_load) dl++;
            if (cyc > 1 && (a_load || b_load)) loads++;
            if (cyc > 1 && a_load && b_load) both++;
            if (done)  begin done_c = cyc; dsamp = int'(d_q); itr = int'(iter_count); end
            if (error) begin err_c = cyc; itr = int'(iter_count); end
            if (done_c != 0 || err_c != 0) break;
            start = (v.glitch != 0 && cyc >= 3 && cyc <= 6) ? 1'b1 : 1'b0;
            step();
            cyc++;
        end
        start = 1'b0;
        chk($sformatf("load_cycle_%0d_%0d", v.a, v.b), first_ok, 1);
        chk($sformatf("done_cycle_%0d_%0d", v.a, v.b), done_c, v.done_cyc);
        chk($sformatf("error_cycle_%0d_%0d", v.a, v.b), err_c, v.err_cyc);
        chk($sformatf("iter_count_%0d_%0d", v.a, v.b), itr, v.iter);
        chk($sformatf("d_load_count_%0d_%0d", v.a, v.b), dl, (v.done_cyc != 0) ? 1 : 0);
        chk($sformatf("single_loads_%0d_%0d", v.a, v.b), loads, v.subs);
        chk($sformatf("dual_load_after_load_%0d_%0d", v.a, v.b), both, 0);
        chk($sformatf("busy_gap_%0d_%0d", v.a, v.b), busy_gap, 0);
        if (v.done_cyc != 0)
            chk($sformatf("d_out_%0d_%0d", v.a, v.b), dsamp, v.d);
        step();
        chk($sformatf("busy_after_%0d_%0d", v.a, v.b), int'(busy), 0);
        step();
        chk($sformatf("stays_idle_%0d_%0d", v.a, v.b), int'(busy), 0);
    endtask

    vec_t vecs[8];

    initial begin
        int t, t1, t2, d1, d2, errs, guard;

        vecs[0] = '{12,  8, 10,  0, 4,  2,  2, 0};
        vecs[1] = '{ 7,  7,  4,  0, 7,  0,  0, 0};
        vecs[2] = '{15,  1, 46,  0, 1, 14, 14, 0};
        vecs[3] = '{ 1, 15, 46,  0, 1, 14, 14, 0};
        vecs[4] = '{ 0,  5,  0, 48, 0, 15, 15, 0};
        vecs[5] = '{ 5,  0,  0, 48, 0, 15, 15, 0};
        vecs[6] = '{ 0,  0,  4,  0, 0,  0,  0, 0};
        vecs[7] = '{12,  8, 10,  0, 4,  2,  2, 1};

        // Reset state
        step();
        chk("reset_busy", int'(busy), 0);
        chk("reset_strobes", int'({enable, sel, a_load, b_load, a_sel, b_sel, d_load}), 0);
        chk("reset_done_error", int'({done, error}), 0);
        chk("reset_iter", int'(iter_count), 0);
        @(negedge clock);
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Reset in cycle 5 of a 12,8 run aborts without a pulse
        ext_a = 4'd12; ext_b = 4'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk("midrst_outputs",
            int'({enable, sel, a_load, b_load, a_sel, b_sel, d_load, busy, done, error}), 0);
        chk("midrst_iter", int'(iter_count), 0);
        @(negedge clock);
        reset = 1'b0;
        step();
        chk("midrst_idle", int'(busy), 0);
        run_op(vecs[0]);

        // start held high: each op is 10 cycles to done plus one IDLE cycle between
        ext_a = 4'd9; ext_b = 4'd6;
        start = 1'b1;
        step();
        t = 1; t1 = 0; t2 = 0; d1 = -1; d2 = -1; errs = 0;
        while (t < 60 && t2 == 0) begin
            if (error) errs++;
            if (done) begin
                if (t1 == 0) begin t1 = t; d1 = int'(d_q); end
                else begin t2 = t; d2 = int'(d_q); end
            end
            if (t2 == 0) begin step(); t++; end
        end
        start = 1'b0;
        chk("b2b_first_done", t1, 10);
        chk("b2b_spacing", t2 - t1, 11);
        chk("b2b_d_out_1", d1, 3);
        chk("b2b_d_out_2", d2, 3);
        chk("b2b_errors", errs, 0);
        guard = 0;
        while (busy && guard < 40) begin step(); guard++; end
        chk("b2b_drain", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
